// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings for the streaming logic unit.
//   OP_NOT..OP_PASS : op[2:0] function codes
//   OP_ACC_BIT      : op bit that selects the accumulator as operand B
package logic_unit_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam int OP_ACC_BIT = 3;

endpackage

// File: rtl/logic_func_comb.sv
// Combinational bitwise function block.
//   func : op[2:0] function select
//   a    : operand A
//   b    : effective operand B (either the b input or the accumulator)
//   res  : bitwise result
module logic_func_comb
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = a;
    case (func)
      OP_NOT:  res = ~a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_PASS: res = a;
      default: res = a;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage streaming bitwise logic unit with valid/ready handshake,
// optional accumulator operand and registered zero/parity flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input beat handshake
//   op                  : op[2:0] function, op[3] use accumulator as operand B
//   a, b                : operands
//   acc_clr             : synchronous accumulator clear (wins over an acc write)
//   out_valid/out_ready : output handshake
//   y, zero, parity     : result, y==0, odd parity of y
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             vld_p1;
  logic [3:0]       op_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] y_p2;
  logic             zero_p2;
  logic             parity_p2;
  logic [WIDTH-1:0] acc_p2;

  logic             adv1;
  logic             adv2;
  logic             acc_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res;

  // S2 frees up when empty or when the consumer takes its result; S1 can
  // then accept in the same cycle it hands over. in_ready depends only on
  // state and out_ready, never on in_valid.
  assign adv2     = vld_p1 && (!vld_p2 || out_ready);
  assign in_ready = !vld_p1 || adv2;
  assign adv1     = in_valid && in_ready;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= 1'b1;
    end else if (adv2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1) begin
      op_p1 <= op;
      a_p1  <= a;
      b_p1  <= b;
    end
  end

  // ---- Stage 2: function evaluation and result register ----
  // The accumulator is read as it stands at the S1->S2 transfer, so
  // back-to-back accumulate ops see the previous op's result directly.
  assign acc_mode = (ACC_EN != 0) && op_p1[OP_ACC_BIT];
  assign b_eff    = acc_mode ? acc_p2 : b_p1;

  logic_func_comb #(.WIDTH(WIDTH)) u_func (
    .func (op_p1[2:0]),
    .a    (a_p1),
    .b    (b_eff),
    .res  (res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      y_p2      <= '0;
      zero_p2   <= 1'b0;
      parity_p2 <= 1'b0;
    end else if (adv2) begin
      vld_p2    <= 1'b1;
      y_p2      <= res;
      zero_p2   <= (res == '0);
      parity_p2 <= odd_parity(res);
    end else if (out_ready) begin
      vld_p2    <= 1'b0;
    end
  end

  // Clear takes priority over a coincident accumulate write; the op that
  // coincides with the clear still used the old value for its result.
  generate
    if (ACC_EN != 0) begin : g_acc
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_p2 <= '0;
        end else if (acc_clr) begin
          acc_p2 <= '0;
        end else if (adv2 && acc_mode) begin
          acc_p2 <= res;
        end
      end
    end else begin : g_no_acc
      assign acc_p2 = '0;
    end
  endgenerate

  assign out_valid = vld_p2;
  assign y         = y_p2;
  assign zero      = zero_p2;
  assign parity    = parity_p2;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8, ACC_EN=1).
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       acc_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       zero;
  logic       parity;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] sweep_exp [8] = '{8'h0F, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'hF0};

  logic_unit_pipe #(.WIDTH(8), .ACC_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat in, then one more edge so its result sits in the output register.
  task automatic send_one(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv);
    op = o; a = av; b = bv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_y", y, 8'h00);
    check("rst_zero", {7'd0, zero}, 8'h00);
    check("rst_parity", {7'd0, parity}, 8'h00);
    check("rst_in_ready", {7'd0, in_ready}, 8'h01);
    #10 rst_n = 1'b1;
    step();

    // Truth sweep: op 0..7 streamed with a=F0, b=CC
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hCC; op = 4'h0; in_valid = 1'b1;
    step();
    check("sweep_latency_not_yet", {7'd0, out_valid}, 8'h00);
    for (int k = 1; k < 8; k++) begin
      op = k[3:0];
      step();
      check("sweep_valid", {7'd0, out_valid}, 8'h01);
      check("sweep_y", y, sweep_exp[k-1]);
    end
    in_valid = 1'b0;
    step();
    check("sweep_valid_last", {7'd0, out_valid}, 8'h01);
    check("sweep_y_last", y, sweep_exp[7]);
    step();
    check("sweep_drained", {7'd0, out_valid}, 8'h00);

    // Flags
    send_one(4'h1, 8'h0F, 8'hF0);
    check("flag0_y", y, 8'h00);
    check("flag0_zero", {7'd0, zero}, 8'h01);
    check("flag0_parity", {7'd0, parity}, 8'h00);
    send_one(4'h7, 8'h07, 8'h00);
    check("flag1_y", y, 8'h07);
    check("flag1_zero", {7'd0, zero}, 8'h00);
    check("flag1_parity", {7'd0, parity}, 8'h01);
    step();

    // Backpressure: 4 beats (PASS of 11,22,33,44) with consumer stalled
    out_ready = 1'b0;
    op = 4'h7; b = 8'h00; a = 8'h11; in_valid = 1'b1;
    step();
    check("bp_in_ready_s2_empty", {7'd0, in_ready}, 8'h01);
    a = 8'h22;
    step();
    check("bp_in_ready_full", {7'd0, in_ready}, 8'h00);
    check("bp_y0", y, 8'h11);
    a = 8'h33;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold_valid", {7'd0, out_valid}, 8'h01);
      check("bp_hold_y", y, 8'h11);
      check("bp_hold_in_ready", {7'd0, in_ready}, 8'h00);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", {7'd0, in_ready}, 8'h01);
    step();
    check("bp_y1", y, 8'h22);
    a = 8'h44;
    step();
    check("bp_y2", y, 8'h33);
    in_valid = 1'b0;
    step();
    check("bp_y3", y, 8'h44);
    check("bp_y3_valid", {7'd0, out_valid}, 8'h01);
    step();
    check("bp_drained", {7'd0, out_valid}, 8'h00);

    // Accumulate chain: OR with acc, a = 01,02,04,08
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    op = 4'hA; b = 8'hAA; a = 8'h01; in_valid = 1'b1;
    step();
    a = 8'h02;
    step();
    check("acc_y0", y, 8'h01);
    a = 8'h04;
    step();
    check("acc_y1", y, 8'h03);
    a = 8'h08;
    step();
    check("acc_y2", y, 8'h07);
    in_valid = 1'b0;
    step();
    check("acc_y3", y, 8'h0F);
    step();
    send_one(4'hA, 8'h00, 8'h55);
    check("acc_readback_0f", y, 8'h0F);

    // Clear coincident with an accumulate op reaching stage 2
    op = 4'hA; a = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("clr_coinc_y", y, 8'h1F);
    send_one(4'hA, 8'h00, 8'h00);
    check("clr_coinc_acc", y, 8'h00);

    // XOR with acc after rebuilding acc = 0F
    send_one(4'hA, 8'h0F, 8'h00);
    check("acc_rebuild", y, 8'h0F);
    send_one(4'hD, 8'hFF, 8'h00);
    check("acc_xor_y", y, 8'hF0);
    send_one(4'hA, 8'h00, 8'h00);
    check("acc_after_xor", y, 8'hF0);

    // Async reset between clock edges with beats in flight
    op = 4'h7; a = 8'h07; in_valid = 1'b1;
    step();
    a = 8'h08;
    step();
    check("prerst_y", y, 8'h07);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", {7'd0, out_valid}, 8'h00);
    check("arst_y", y, 8'h00);
    check("arst_zero", {7'd0, zero}, 8'h00);
    check("arst_parity", {7'd0, parity}, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("postrst_no_stale", {7'd0, out_valid}, 8'h00);
    end
    send_one(4'hA, 8'h00, 8'h00);
    check("postrst_acc_cleared", y, 8'h00);
    check("postrst_zero", {7'd0, zero}, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
